// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
//   Control FSM for a multi-cycle MIPS datapath that shares one PC, IR,
//   register file, ALU and unified memory across the FETCH / DECODE / EXEC /
//   MEM / WB steps. It steers the datapath muxes and write enables, handshakes
//   with the memory port, flags unknown opcodes, and counts retired
//   instructions.
//
// Ports
//   clk_i         rising-edge clock
//   rst_i         asynchronous reset, active low
//   instr_op_i    opcode field IR[31:26]
//   zero_i        ALU zero flag (branch resolution)
//   mem_ack_i     memory done: read data valid / write accepted this cycle
//   mem_req_o     memory access request
//   mem_we_o      1 = write (sw), 0 = read
//   iord_o        memory address select: 0 = PC, 1 = ALUOut
//   ir_write_o    load IR from memory data
//   pc_write_o    load PC
//   pc_src_o      00 = ALU (PC+4), 01 = branch target, 10 = jump target
//   reg_write_o   register file write enable
//   reg_dst_o     00 = rt, 01 = rd, 10 = $31
//   mem_to_reg_o  00 = ALUOut, 01 = MDR, 11 = PC (link)
//   alu_src_a_o   0 = PC, 1 = rs
//   alu_src_b_o   00 = rt, 01 = const 4, 10 = ext imm, 11 = branch offset<<2
//   alu_op_o      000 R(funct), 001 add, 010 sltiu, 011 sub, 100 lui, 101 ori
//   illegal_o     one-cycle pulse for an unknown opcode in DECODE
//   state_o       current state (debug)
//   retired_o     retired-instruction count, wraps modulo 2^CNT_W
// ---------------------------------------------------------------------------
module multi_cycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       instr_op_i,
  input  logic             zero_i,
  input  logic             mem_ack_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             reg_write_o,
  output logic [1:0]       reg_dst_o,
  output logic [1:0]       mem_to_reg_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [2:0]       alu_op_o,
  output logic             illegal_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_BRANCH = 3'd5;
  localparam logic [2:0] S_JUMP   = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [2:0]       stateR;
  logic [2:0]       nextStateS;
  logic             retireS;
  logic [CNT_W-1:0] retiredR;

  logic       memReqS, memWeS, iordS, irWriteS, pcWriteS, regWriteS;
  logic       aluSrcAS, illegalS;
  logic [1:0] pcSrcS, regDstS, memToRegS, aluSrcBS;
  logic [2:0] aluOpS;

  // Next-state, retire strobe and raw (un-gated) control decode.
  always_comb begin
    nextStateS = S_FETCH;
    retireS    = 1'b0;
    memReqS    = 1'b0;
    memWeS     = 1'b0;
    iordS      = 1'b0;
    irWriteS   = 1'b0;
    pcWriteS   = 1'b0;
    pcSrcS     = 2'b00;
    regWriteS  = 1'b0;
    regDstS    = 2'b00;
    memToRegS  = 2'b00;
    aluSrcAS   = 1'b0;
    aluSrcBS   = 2'b00;
    aluOpS     = 3'b000;
    illegalS   = 1'b0;
    case (stateR)
      S_FETCH: begin
        // ALU computes PC+4 while the instruction word is being read.
        memReqS  = 1'b1;
        aluSrcBS = 2'b01;
        aluOpS   = 3'b001;
        if (mem_ack_i) begin
          irWriteS   = 1'b1;
          pcWriteS   = 1'b1;
          nextStateS = S_DECODE;
        end else begin
          nextStateS = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only has to compare.
        aluSrcBS = 2'b11;
        aluOpS   = 3'b001;
        case (instr_op_i)
          OP_RTYPE, OP_ADDI, OP_SLTIU, OP_LUI,
          OP_ORI, OP_LW, OP_SW:            nextStateS = S_EXEC;
          OP_BEQ, OP_BNE:                  nextStateS = S_BRANCH;
          OP_J, OP_JAL:                    nextStateS = S_JUMP;
          default: begin
            illegalS   = 1'b1;
            nextStateS = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        aluSrcAS   = 1'b1;
        aluSrcBS   = 2'b10;
        nextStateS = S_WB;
        case (instr_op_i)
          OP_RTYPE: begin
            aluSrcBS = 2'b00;
            aluOpS   = 3'b000;
          end
          OP_ADDI:  aluOpS = 3'b001;
          OP_LW, OP_SW: begin
            aluOpS     = 3'b001;
            nextStateS = S_MEM;
          end
          OP_SLTIU: aluOpS = 3'b010;
          OP_LUI:   aluOpS = 3'b100;
          OP_ORI:   aluOpS = 3'b101;
          default:  aluOpS = 3'b000;
        endcase
      end
      S_MEM: begin
        // Request stays up until the ack; a store finishes here.
        memReqS = 1'b1;
        iordS   = 1'b1;
        memWeS  = (instr_op_i == OP_SW);
        if (mem_ack_i) begin
          if (instr_op_i == OP_SW) begin
            nextStateS = S_FETCH;
            retireS    = 1'b1;
          end else begin
            nextStateS = S_WB;
          end
        end else begin
          nextStateS = S_MEM;
        end
      end
      S_WB: begin
        regWriteS  = 1'b1;
        nextStateS = S_FETCH;
        retireS    = 1'b1;
        case (instr_op_i)
          OP_RTYPE: regDstS   = 2'b01;
          OP_LW:    memToRegS = 2'b01;
          default:  regDstS   = 2'b00;
        endcase
      end
      S_BRANCH: begin
        aluSrcAS   = 1'b1;
        aluOpS     = 3'b011;
        pcSrcS     = 2'b01;
        nextStateS = S_FETCH;
        retireS    = 1'b1;
        case (instr_op_i)
          OP_BEQ:  pcWriteS = zero_i;
          OP_BNE:  pcWriteS = ~zero_i;
          default: pcWriteS = 1'b0;
        endcase
      end
      S_JUMP: begin
        // PC already holds PC+4 from FETCH, so jal links straight from PC.
        pcSrcS     = 2'b10;
        pcWriteS   = 1'b1;
        nextStateS = S_FETCH;
        retireS    = 1'b1;
        if (instr_op_i == OP_JAL) begin
          regWriteS = 1'b1;
          regDstS   = 2'b10;
          memToRegS = 2'b11;
        end else begin
          regWriteS = 1'b0;
        end
      end
      default: nextStateS = S_FETCH;
    endcase
  end

  // Output drive: during reset only the fetch request may show, so an ack
  // arriving while reset is held can never fire an enable.
  always_comb begin
    mem_req_o = memReqS;
    if (rst_i) begin
      mem_we_o     = memWeS;
      iord_o       = iordS;
      ir_write_o   = irWriteS;
      pc_write_o   = pcWriteS;
      pc_src_o     = pcSrcS;
      reg_write_o  = regWriteS;
      reg_dst_o    = regDstS;
      mem_to_reg_o = memToRegS;
      alu_src_a_o  = aluSrcAS;
      alu_src_b_o  = aluSrcBS;
      alu_op_o     = aluOpS;
      illegal_o    = illegalS;
    end else begin
      mem_we_o     = 1'b0;
      iord_o       = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      pc_src_o     = 2'b00;
      reg_write_o  = 1'b0;
      reg_dst_o    = 2'b00;
      mem_to_reg_o = 2'b00;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 2'b00;
      alu_op_o     = 3'b000;
      illegal_o    = 1'b0;
    end
  end

  // State register and retired-instruction counter.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stateR   <= S_FETCH;
      retiredR <= '0;
    end else begin
      stateR <= nextStateS;
      if (retireS) begin
        retiredR <= retiredR + CNT_ONE;
      end else begin
        retiredR <= retiredR;
      end
    end
  end

  assign state_o   = stateR;
  assign retired_o = retiredR;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
module tb_multi_cycle_ctrl;

  typedef struct packed {
    logic [2:0]  state;
    logic        memReq;
    logic        memWe;
    logic        iord;
    logic        irWrite;
    logic        pcWrite;
    logic [1:0]  pcSrc;
    logic        regWrite;
    logic [1:0]  regDst;
    logic [1:0]  memToReg;
    logic        aluSrcA;
    logic [1:0]  aluSrcB;
    logic [2:0]  aluOp;
    logic        illegal;
    logic [31:0] retired;
  } outVec_t;

  logic        clk = 1'b0;
  logic        rstI;
  logic [5:0]  opI;
  logic        zeroI;
  logic        ackI;
  logic        memReqO, memWeO, iordO, irWriteO, pcWriteO, regWriteO;
  logic        aluSrcAO, illegalO;
  logic [1:0]  pcSrcO, regDstO, memToRegO, aluSrcBO;
  logic [2:0]  aluOpO, stateO;
  logic [31:0] retiredO;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] expCount = 32'd0;
  outVec_t     expQ[$];
  string       nameQ[$];

  multi_cycle_ctrl #(.CNT_W(32)) dut (
    .clk_i(clk), .rst_i(rstI), .instr_op_i(opI), .zero_i(zeroI),
    .mem_ack_i(ackI), .mem_req_o(memReqO), .mem_we_o(memWeO),
    .iord_o(iordO), .ir_write_o(irWriteO), .pc_write_o(pcWriteO),
    .pc_src_o(pcSrcO), .reg_write_o(regWriteO), .reg_dst_o(regDstO),
    .mem_to_reg_o(memToRegO), .alu_src_a_o(aluSrcAO), .alu_src_b_o(aluSrcBO),
    .alu_op_o(aluOpO), .illegal_o(illegalO), .state_o(stateO),
    .retired_o(retiredO)
  );

  always #5 clk = ~clk;

  function automatic outVec_t sampleDut();
    outVec_t v;
    v = '{stateO, memReqO, memWeO, iordO, irWriteO, pcWriteO, pcSrcO,
          regWriteO, regDstO, memToRegO, aluSrcAO, aluSrcBO, aluOpO,
          illegalO, retiredO};
    return v;
  endfunction

  task automatic check(input string name, input outVec_t act, input outVec_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got state=%0d ctrl=%h retired=%0d, want state=%0d ctrl=%h retired=%0d",
               name, act.state, act[53:32], act.retired, exp.state, exp[53:32], exp.retired);
    end
  endtask

  // Reference instruction classes.
  typedef enum {C_R, C_ADDI, C_SLTIU, C_LUI, C_ORI, C_LW, C_SW,
                C_BEQ, C_BNE, C_J, C_JAL, C_ILL} cls_t;

  function automatic cls_t classify(input logic [5:0] op);
    case (op)
      6'd0:  return C_R;
      6'd8:  return C_ADDI;
      6'd11: return C_SLTIU;
      6'd15: return C_LUI;
      6'd13: return C_ORI;
      6'd35: return C_LW;
      6'd43: return C_SW;
      6'd4:  return C_BEQ;
      6'd5:  return C_BNE;
      6'd2:  return C_J;
      6'd3:  return C_JAL;
      default: return C_ILL;
    endcase
  endfunction

  function automatic outVec_t base(input logic [2:0] st);
    outVec_t v;
    v = '0;
    v.state   = st;
    v.retired = expCount;
    return v;
  endfunction

  // One clock: drive inputs just after the edge and queue what should be seen.
  task automatic step(input string name, input logic [5:0] op, input logic ack,
                      input logic z, input outVec_t e);
    @(posedge clk);
    #1;
    opI   = op;
    ackI  = ack;
    zeroI = z;
    expQ.push_back(e);
    nameQ.push_back(name);
  endtask

  // Whole instruction as seen from the datapath, from fetch to retire.
  // zSel: 0/1 forces zero_i in BRANCH, 2 = random. stopInMem leaves the
  // access pending after the MEM wait cycles.
  task automatic runInstr(input logic [5:0] op, input int fw, input int mw,
                          input int zSel, input bit stopInMem);
    outVec_t e;
    cls_t    c;
    logic    z;
    c = classify(op);
    for (int i = 0; i < fw; i++) begin
      e = base(3'd0); e.memReq = 1'b1; e.aluSrcB = 2'b01; e.aluOp = 3'b001;
      step("fetch_wait", op, 1'b0, 1'($urandom_range(0, 1)), e);
    end
    e = base(3'd0); e.memReq = 1'b1; e.aluSrcB = 2'b01; e.aluOp = 3'b001;
    e.irWrite = 1'b1; e.pcWrite = 1'b1;
    step("fetch_ack", op, 1'b1, 1'($urandom_range(0, 1)), e);

    e = base(3'd1); e.aluSrcB = 2'b11; e.aluOp = 3'b001;
    e.illegal = (c == C_ILL);
    step("decode", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
    if (c == C_ILL) return;

    if (c == C_BEQ || c == C_BNE) begin
      z = (zSel == 2) ? 1'($urandom_range(0, 1)) : 1'(zSel);
      e = base(3'd5); e.aluSrcA = 1'b1; e.aluOp = 3'b011; e.pcSrc = 2'b01;
      e.pcWrite = (c == C_BEQ) ? z : !z;
      step("branch", op, 1'($urandom_range(0, 1)), z, e);
      expCount++;
      return;
    end
    if (c == C_J || c == C_JAL) begin
      e = base(3'd6); e.pcSrc = 2'b10; e.pcWrite = 1'b1;
      if (c == C_JAL) begin
        e.regWrite = 1'b1; e.regDst = 2'b10; e.memToReg = 2'b11;
      end
      step("jump", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
      expCount++;
      return;
    end

    e = base(3'd2); e.aluSrcA = 1'b1;
    e.aluSrcB = (c == C_R) ? 2'b00 : 2'b10;
    case (c)
      C_R:     e.aluOp = 3'b000;
      C_SLTIU: e.aluOp = 3'b010;
      C_LUI:   e.aluOp = 3'b100;
      C_ORI:   e.aluOp = 3'b101;
      default: e.aluOp = 3'b001;
    endcase
    step("exec", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);

    if (c == C_LW || c == C_SW) begin
      for (int i = 0; i < mw; i++) begin
        e = base(3'd3); e.memReq = 1'b1; e.iord = 1'b1; e.memWe = (c == C_SW);
        step("mem_wait", op, 1'b0, 1'($urandom_range(0, 1)), e);
      end
      if (stopInMem) return;
      e = base(3'd3); e.memReq = 1'b1; e.iord = 1'b1; e.memWe = (c == C_SW);
      step("mem_ack", op, 1'b1, 1'($urandom_range(0, 1)), e);
      if (c == C_SW) begin
        expCount++;
        return;
      end
    end

    e = base(3'd4); e.regWrite = 1'b1;
    e.regDst   = (c == C_R) ? 2'b01 : 2'b00;
    e.memToReg = (c == C_LW) ? 2'b01 : 2'b00;
    step("wb", op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), e);
    expCount++;
  endtask

  // Monitor: every cycle with a queued expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      check(nameQ.pop_front(), sampleDut(), expQ.pop_front());
    end
  end

  initial begin
    outVec_t e;
    logic [5:0] opTab [0:11];
    logic [5:0] op;
    opTab[0] = 6'd0;  opTab[1] = 6'd8;  opTab[2]  = 6'd11; opTab[3]  = 6'd15;
    opTab[4] = 6'd13; opTab[5] = 6'd35; opTab[6]  = 6'd43; opTab[7]  = 6'd4;
    opTab[8] = 6'd5;  opTab[9] = 6'd2;  opTab[10] = 6'd3;  opTab[11] = 6'd63;

    rstI = 1'b0; ackI = 1'b1; opI = 6'd0; zeroI = 1'b0;
    #3;
    e = base(3'd0); e.memReq = 1'b1;
    check("reset_async", sampleDut(), e);
    @(posedge clk); #1;
    check("reset_edge_ack", sampleDut(), e);
    rstI = 1'b1; ackI = 1'b0;

    // Directed cases.
    runInstr(6'd0,  0, 0, 2, 1'b0);   // add
    runInstr(6'd35, 0, 2, 2, 1'b0);   // lw, two memory wait cycles
    runInstr(6'd4,  0, 0, 1, 1'b0);   // beq taken
    runInstr(6'd4,  0, 0, 0, 1'b0);   // beq not taken
    runInstr(6'd5,  0, 0, 1, 1'b0);   // bne not taken
    runInstr(6'd5,  0, 0, 0, 1'b0);   // bne taken
    runInstr(6'd3,  0, 0, 2, 1'b0);   // jal
    runInstr(6'd63, 0, 0, 2, 1'b0);   // illegal
    runInstr(6'd43, 1, 1, 2, 1'b0);   // sw with waits

    // Randomized stream.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 4) == 0) op = 6'($urandom_range(0, 63));
      else op = opTab[$urandom_range(0, 11)];
      runInstr(op, $urandom_range(0, 2), $urandom_range(0, 3), 2, 1'b0);
    end

    // Reset while a store sits in MEM with the ack arriving.
    runInstr(6'd43, 0, 1, 2, 1'b1);
    @(negedge clk); #2;
    ackI = 1'b1; rstI = 1'b0;
    expCount = 32'd0;
    #1;
    e = base(3'd0); e.memReq = 1'b1;
    check("reset_in_mem", sampleDut(), e);
    @(posedge clk); #1;
    check("reset_in_mem_edge", sampleDut(), e);
    rstI = 1'b1; ackI = 1'b0;

    for (int n = 0; n < 20; n++) begin
      runInstr(opTab[$urandom_range(0, 11)], $urandom_range(0, 1),
               $urandom_range(0, 2), 2, 1'b0);
    end

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
